wts_wave_ram_scheduler: RTL and testbench



---
 rtl/wts_wave_ram_scheduler.sv | 154 +++++++++++++++
 tb/tb_wts_wave_ram_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wts_wave_ram_scheduler.sv
// Wave-table RAM time-slot scheduler: one read slot per voice channel per frame,
// remaining cycles service a one-deep CPU read/write request register.
module wts_wave_ram_scheduler #(
    parameter int CH_NUM    = 6,
    parameter int FRAME_LEN = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sched_en,
    output logic [2:0] ch_sel,
    input  logic [4:0] ch_ptr,
    output logic       sample_valid,
    output logic [2:0] sample_ch,
    output logic [7:0] sample_data,
    output logic       frame_start,
    input  logic       cpu_wrreq,
    input  logic       cpu_rdreq,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_busy,
    output logic [7:0] cpu_q,
    output logic       cpu_q_valid,
    output logic       cpu_overrun,
    output logic [7:0] ram_addr,
    output logic       ram_re,
    output logic       ram_we,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata,
    output logic [2:0] cpu_state
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PEND_WR  = 3'd1;
    localparam logic [2:0] S_PEND_RD  = 3'd2;
    localparam logic [2:0] S_RD_WAIT1 = 3'd3;
    localparam logic [2:0] S_RD_WAIT2 = 3'd4;

    localparam logic [7:0] FCNT_LAST = 8'(FRAME_LEN - 1);
    localparam logic [7:0] CH_LIMIT  = 8'(CH_NUM);
    localparam logic [3:0] CH_LIMIT4 = 4'(CH_NUM);

    logic [7:0] fcnt;
    logic [2:0] state;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       req_oor;
    logic       ch_slot;
    logic       cpu_slot;
    logic       s1_valid;
    logic       s2_valid;
    logic [2:0] s1_ch;
    logic [2:0] s2_ch;

    // Slot type follows sched_en combinationally, so a change applies to the current cycle.
    assign ch_slot     = sched_en && !reset && (fcnt < CH_LIMIT);
    assign cpu_slot    = !ch_slot;
    assign ch_sel      = ch_slot ? fcnt[2:0] : 3'd0;
    assign frame_start = (fcnt == 8'd0) && !reset;
    assign req_oor     = ({1'b0, req_addr[7:5]} >= CH_LIMIT4);
    assign cpu_busy    = (state != S_IDLE);
    assign cpu_state   = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            fcnt         <= 8'd0;
            state        <= S_IDLE;
            req_addr     <= 8'd0;
            req_wdata    <= 8'd0;
            ram_addr     <= 8'd0;
            ram_re       <= 1'b0;
            ram_we       <= 1'b0;
            ram_wdata    <= 8'd0;
            s1_valid     <= 1'b0;
            s2_valid     <= 1'b0;
            s1_ch        <= 3'd0;
            s2_ch        <= 3'd0;
            sample_valid <= 1'b0;
            sample_ch    <= 3'd0;
            sample_data  <= 8'd0;
            cpu_q        <= 8'd0;
            cpu_q_valid  <= 1'b0;
            cpu_overrun  <= 1'b0;
        end else begin
            fcnt        <= (fcnt == FCNT_LAST) ? 8'd0 : 8'(fcnt + 8'd1);
            ram_re      <= 1'b0;
            ram_we      <= 1'b0;
            cpu_q_valid <= 1'b0;
            cpu_overrun <= 1'b0;
            s1_valid    <= 1'b0;

            if (ch_slot) begin
                ram_re   <= 1'b1;
                ram_addr <= {fcnt[2:0], ch_ptr};
                s1_valid <= 1'b1;
                s1_ch    <= fcnt[2:0];
            end

            // Tag travels alongside the RAM access; rdata arrives in the s2 cycle.
            s2_valid     <= s1_valid;
            s2_ch        <= s1_ch;
            sample_valid <= s2_valid;
            if (s2_valid) begin
                sample_ch   <= s2_ch;
                sample_data <= ram_rdata;
            end

            case (state)
                S_IDLE: begin
                    if (cpu_wrreq) begin
                        state       <= S_PEND_WR;
                        req_addr    <= cpu_addr;
                        req_wdata   <= cpu_wdata;
                        cpu_overrun <= cpu_rdreq;
                    end else if (cpu_rdreq) begin
                        state    <= S_PEND_RD;
                        req_addr <= cpu_addr;
                    end
                end
                S_PEND_WR: begin
                    if (cpu_slot) begin
                        if (!req_oor) begin
                            ram_we    <= 1'b1;
                            ram_addr  <= req_addr;
                            ram_wdata <= req_wdata;
                        end
                        state <= S_IDLE;
                    end
                end
                S_PEND_RD: begin
                    if (cpu_slot) begin
                        if (!req_oor) begin
                            ram_re   <= 1'b1;
                            ram_addr <= req_addr;
                        end
                        state <= S_RD_WAIT1;
                    end
                end
                S_RD_WAIT1: state <= S_RD_WAIT2;
                S_RD_WAIT2: begin
                    cpu_q       <= req_oor ? 8'hFF : ram_rdata;
                    cpu_q_valid <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // A busy request register drops any new request; the pending one carries on.
            if ((state != S_IDLE) && (cpu_wrreq || cpu_rdreq)) begin
                cpu_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wts_wave_ram_scheduler.sv
// Directed bench for wts_wave_ram_scheduler with a behavioural synchronous RAM
// preloaded so that each location holds its own address.
module tb_wts_wave_ram_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       sched_en;
    logic [2:0] ch_sel;
    logic [4:0] ch_ptr;
    logic       sample_valid;
    logic [2:0] sample_ch;
    logic [7:0] sample_data;
    logic       frame_start;
    logic       cpu_wrreq;
    logic       cpu_rdreq;
    logic [7:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_busy;
    logic [7:0] cpu_q;
    logic       cpu_q_valid;
    logic       cpu_overrun;
    logic [7:0] ram_addr;
    logic       ram_re;
    logic       ram_we;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic [2:0] cpu_state;

    logic [7:0] mem [256];
    logic       mem_init;
    int         cyc;
    int         total;
    int         bad;

    always #5 clk = ~clk;

    assign ch_ptr = 5'(ch_sel) + 5'd3;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
        end else begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            if (ram_re) ram_rdata <= mem[ram_addr];
        end
    end

    wts_wave_ram_scheduler #(.CH_NUM(6), .FRAME_LEN(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .sched_en     (sched_en),
        .ch_sel       (ch_sel),
        .ch_ptr       (ch_ptr),
        .sample_valid (sample_valid),
        .sample_ch    (sample_ch),
        .sample_data  (sample_data),
        .frame_start  (frame_start),
        .cpu_wrreq    (cpu_wrreq),
        .cpu_rdreq    (cpu_rdreq),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_busy     (cpu_busy),
        .cpu_q        (cpu_q),
        .cpu_q_valid  (cpu_q_valid),
        .cpu_overrun  (cpu_overrun),
        .ram_addr     (ram_addr),
        .ram_re       (ram_re),
        .ram_we       (ram_we),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata),
        .cpu_state    (cpu_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic wait_f(input int f);
        for (int k = 0; k < 16 && (cyc % 16) != f; k++) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0; cyc = 0;
        reset = 1'b1; sched_en = 1'b0; mem_init = 1'b1;
        cpu_wrreq = 1'b0; cpu_rdreq = 1'b0; cpu_addr = 8'd0; cpu_wdata = 8'd0;
        tick();
        mem_init = 1'b0;
        tick(2);

        // Reset state, still inside reset
        check("rst_busy",  32'(cpu_busy), 0);
        check("rst_q",     32'(cpu_q), 0);
        check("rst_qv",    32'(cpu_q_valid), 0);
        check("rst_re",    32'(ram_re), 0);
        check("rst_we",    32'(ram_we), 0);
        check("rst_sv",    32'(sample_valid), 0);
        check("rst_fs",    32'(frame_start), 0);
        check("rst_ovr",   32'(cpu_overrun), 0);
        check("rst_state", 32'(cpu_state), 0);

        // Frame cadence: release reset, first cycle is fcnt=0
        reset = 1'b0; sched_en = 1'b1; cyc = 0;
        #1;
        for (int i = 0; i < 18; i++) begin
            int f;
            f = i % 16;
            check("fs",     32'(frame_start), 32'(f == 0));
            check("ch_sel", 32'(ch_sel), (f < 6) ? f : 0);
            check("re",     32'(ram_re), 32'(f >= 1 && f <= 6));
            check("we",     32'(ram_we), 0);
            if (f >= 1 && f <= 6) check("re_addr", 32'(ram_addr), ((f - 1) << 5) | (f + 2));
            check("sv", 32'(sample_valid), 32'(f >= 3 && f <= 8));
            if (f >= 3 && f <= 8) begin
                check("s_ch",   32'(sample_ch), f - 3);
                check("s_data", 32'(sample_data), ((f - 3) << 5) | f);
            end
            tick();
        end

        // CPU write arriving at fcnt=1 waits through channel slots 2..5
        wait_f(1);
        cpu_wrreq = 1'b1; cpu_addr = 8'h25; cpu_wdata = 8'h5A;
        tick();
        cpu_wrreq = 1'b0;
        for (int j = 1; j <= 7; j++) begin
            check("dw_we",   32'(ram_we), 32'(j == 6));
            check("dw_re",   32'(ram_re), 32'(j <= 5));
            check("dw_busy", 32'(cpu_busy), 32'(j <= 5));
            check("dw_excl", 32'(ram_re && ram_we), 0);
            check("dw_ovr",  32'(cpu_overrun), 0);
            if (j == 6) begin
                check("dw_addr",  32'(ram_addr), 32'h25);
                check("dw_wdata", 32'(ram_wdata), 32'h5A);
            end
            tick();
        end

        // Read back 0x25 in a CPU slot
        wait_f(10);
        cpu_rdreq = 1'b1; cpu_addr = 8'h25;
        tick();
        cpu_rdreq = 1'b0;
        check("rb_busy1",  32'(cpu_busy), 1);
        check("rb_state1", 32'(cpu_state), 2);
        check("rb_re1",    32'(ram_re), 0);
        tick();
        check("rb_re2",    32'(ram_re), 1);
        check("rb_addr2",  32'(ram_addr), 32'h25);
        check("rb_state2", 32'(cpu_state), 3);
        tick();
        check("rb_busy3",  32'(cpu_busy), 1);
        check("rb_qv3",    32'(cpu_q_valid), 0);
        check("rb_state3", 32'(cpu_state), 4);
        tick();
        check("rb_qv4",    32'(cpu_q_valid), 1);
        check("rb_q4",     32'(cpu_q), 32'h5A);
        check("rb_busy4",  32'(cpu_busy), 0);
        tick();
        check("rb_qv5",    32'(cpu_q_valid), 0);
        check("rb_qhold",  32'(cpu_q), 32'h5A);

        // Overrun: read, then a write one cycle later is dropped
        wait_f(10);
        cpu_rdreq = 1'b1; cpu_addr = 8'h44;
        tick();
        cpu_rdreq = 1'b0;
        cpu_wrreq = 1'b1; cpu_addr = 8'h30; cpu_wdata = 8'h77;
        check("ov_ovr1",  32'(cpu_overrun), 0);
        check("ov_busy1", 32'(cpu_busy), 1);
        tick();
        cpu_wrreq = 1'b0;
        check("ov_ovr2",  32'(cpu_overrun), 1);
        check("ov_re2",   32'(ram_re), 1);
        check("ov_addr2", 32'(ram_addr), 32'h44);
        check("ov_we2",   32'(ram_we), 0);
        tick();
        check("ov_ovr3",  32'(cpu_overrun), 0);
        check("ov_we3",   32'(ram_we), 0);
        tick();
        check("ov_qv4",   32'(cpu_q_valid), 1);
        check("ov_q4",    32'(cpu_q), 32'h44);
        check("ov_we4",   32'(ram_we), 0);
        check("ov_busy4", 32'(cpu_busy), 0);
        tick();
        check("ov_we5",   32'(ram_we), 0);
        check("ov_busy5", 32'(cpu_busy), 0);

        // Simultaneous write and read in IDLE: write wins, overrun flagged
        wait_f(10);
        cpu_wrreq = 1'b1; cpu_rdreq = 1'b1; cpu_addr = 8'h41; cpu_wdata = 8'hC3;
        tick();
        cpu_wrreq = 1'b0; cpu_rdreq = 1'b0;
        check("sim_ovr1",   32'(cpu_overrun), 1);
        check("sim_state1", 32'(cpu_state), 1);
        tick();
        check("sim_we2",    32'(ram_we), 1);
        check("sim_addr2",  32'(ram_addr), 32'h41);
        check("sim_wdata2", 32'(ram_wdata), 32'hC3);
        check("sim_re2",    32'(ram_re), 0);
        check("sim_ovr2",   32'(cpu_overrun), 0);
        check("sim_busy2",  32'(cpu_busy), 0);
        tick();
        check("sim_we3",    32'(ram_we), 0);
        check("sim_qv3",    32'(cpu_q_valid), 0);

        // Out-of-range read (channel 7) then out-of-range write (channel 6)
        wait_f(10);
        cpu_rdreq = 1'b1; cpu_addr = 8'hE0;
        tick();
        cpu_rdreq = 1'b0;
        check("oor_busy1", 32'(cpu_busy), 1);
        tick();
        check("oor_re2",    32'(ram_re), 0);
        check("oor_state2", 32'(cpu_state), 3);
        tick();
        check("oor_qv3",   32'(cpu_q_valid), 0);
        tick();
        check("oor_qv4",   32'(cpu_q_valid), 1);
        check("oor_q4",    32'(cpu_q), 32'hFF);
        check("oor_busy4", 32'(cpu_busy), 0);
        cpu_wrreq = 1'b1; cpu_addr = 8'hC0; cpu_wdata = 8'h11;
        tick();
        cpu_wrreq = 1'b0;
        check("oow_busy1", 32'(cpu_busy), 1);
        tick();
        check("oow_we2",   32'(ram_we), 0);
        check("oow_re2",   32'(ram_re), 0);
        check("oow_busy2", 32'(cpu_busy), 0);
        check("oow_ovr2",  32'(cpu_overrun), 0);

        // sched_en dropped mid channel window; write goes out at m+2
        wait_f(2);
        sched_en = 1'b0;
        cpu_wrreq = 1'b1; cpu_addr = 8'h12; cpu_wdata = 8'h99;
        #1;
        check("se_ch_sel", 32'(ch_sel), 0);
        tick();
        cpu_wrreq = 1'b0;
        check("se_re1",    32'(ram_re), 0);
        check("se_busy1",  32'(cpu_busy), 1);
        check("se_sv1",    32'(sample_valid), 1);
        check("se_sch1",   32'(sample_ch), 0);
        check("se_sdat1",  32'(sample_data), 32'h03);
        tick();
        check("se_we2",    32'(ram_we), 1);
        check("se_addr2",  32'(ram_addr), 32'h12);
        check("se_wdata2", 32'(ram_wdata), 32'h99);
        check("se_sv2",    32'(sample_valid), 1);
        check("se_sch2",   32'(sample_ch), 1);
        tick();
        check("se_we3",    32'(ram_we), 0);
        check("se_sv3",    32'(sample_valid), 0);
        check("se_busy3",  32'(cpu_busy), 0);
        for (int j = 0; j < 20; j++) begin
            check("se_drain_sv", 32'(sample_valid), 0);
            check("se_drain_re", 32'(ram_re), 0);
            tick();
        end

        // Reset asserted while the read sits in RD_WAIT1
        cpu_rdreq = 1'b1; cpu_addr = 8'h12;
        tick();
        cpu_rdreq = 1'b0;
        check("rr_state1", 32'(cpu_state), 2);
        tick();
        check("rr_state2", 32'(cpu_state), 3);
        check("rr_re2",    32'(ram_re), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0; cyc = 0;
        #1;
        check("rr_qv0",    32'(cpu_q_valid), 0);
        check("rr_busy0",  32'(cpu_busy), 0);
        check("rr_q0",     32'(cpu_q), 0);
        check("rr_fs0",    32'(frame_start), 1);
        check("rr_state0", 32'(cpu_state), 0);
        check("rr_re0",    32'(ram_re), 0);
        for (int j = 1; j <= 3; j++) begin
            tick();
            check("rr_qv", 32'(cpu_q_valid), 0);
            check("rr_q",  32'(cpu_q), 0);
            check("rr_fs", 32'(frame_start), 0);
        end
        wait_f(0);
        check("rr_fs16", 32'(frame_start), 1);
        check("rr_re16", 32'(ram_re), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
